// File: rtl/urd_rx_fd_job_queue_if.sv
// Port bundle for the URD RX frame-descriptor job queue.
// The slave side is the queue; the master side is the controller plus the FD engine.
interface urd_rx_fd_job_queue_if #(
    parameter int DEPTH = 4,
    parameter int JOB_W = 64,
    parameter int ERR_W = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             rsv;
    logic             wr_job;
    logic             wr_err_job;
    logic [JOB_W-1:0] wr_data;
    logic [ERR_W-1:0] wr_err_id;
    logic             slot_available;
    logic             slot_available_early;
    logic             jq_valid;
    logic             jq_ready;
    logic [JOB_W-1:0] jq_data;
    logic             jq_err;
    logic [ERR_W-1:0] jq_err_id;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             rsv_err;
    logic [15:0]      err_job_cnt;

    modport master (
        output rsv, wr_job, wr_err_job, wr_data, wr_err_id, jq_ready,
        input  slot_available, slot_available_early, jq_valid, jq_data, jq_err,
               jq_err_id, count, overflow, rsv_err, err_job_cnt
    );

    modport slave (
        input  rsv, wr_job, wr_err_job, wr_data, wr_err_id, jq_ready,
        output slot_available, slot_available_early, jq_valid, jq_data, jq_err,
               jq_err_id, count, overflow, rsv_err, err_job_cnt
    );
endinterface

// File: rtl/urd_rx_fd_job_queue.sv
// FD job queue: first-word-fall-through FIFO with slot reservations for the frame-decode controller.
// Optional error-job counter enabled by defining URD_RX_FDJQ_ERR_CNT_EN.
module urd_rx_fd_job_queue #(
    parameter int DEPTH = 4,
    parameter int JOB_W = 64,
    parameter int ERR_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    urd_rx_fd_job_queue_if.slave io
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_S  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic             err;
        logic [ERR_W-1:0] err_id;
        logic [JOB_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, resv_q, resv_d, resv_mid;
    logic             overflow_q, overflow_d, rsv_err_q, rsv_err_d;
    logic             jq_valid, pop, wr, wr_acc, is_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign jq_valid = (count_q != '0);
    assign pop      = jq_valid & io.jq_ready;
    assign wr       = io.wr_job | io.wr_err_job;
    assign is_err   = io.wr_err_job;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        rsv_err_d  = rsv_err_q;
        resv_mid   = resv_q;
        wr_acc     = 1'b0;
        // A write spends an existing reservation before any new one is judged.
        if (wr) begin
            if (resv_q != '0) begin
                wr_acc   = 1'b1;
                resv_mid = resv_q - 1'b1;
            end else if (({1'b0, count_q} < DEPTH_S) || pop) begin
                wr_acc = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(pop);
        resv_d  = resv_mid;
        if (io.rsv) begin
            if (({1'b0, count_d} + {1'b0, resv_mid}) < DEPTH_S) resv_d = resv_mid + 1'b1;
            else                                                 rsv_err_d = 1'b1;
        end
        // When full, wr_ptr == rd_ptr: a same-cycle push overwrites the entry being popped.
        if (wr_acc) begin
            mem_d[wr_ptr_q] = '{err: is_err, err_id: (is_err ? io.wr_err_id : '0), data: io.wr_data};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            resv_q     <= '0;
            overflow_q <= 1'b0;
            rsv_err_q  <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            resv_q     <= resv_d;
            overflow_q <= overflow_d;
            rsv_err_q  <= rsv_err_d;
        end
    end

`ifdef URD_RX_FDJQ_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (wr_acc && is_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign io.err_job_cnt = err_cnt_q;
`else
    assign io.err_job_cnt = 16'd0;
`endif

    assign io.slot_available       = ({1'b0, count_q} + {1'b0, resv_q}) < DEPTH_S;
    assign io.slot_available_early = io.slot_available | pop;
    assign io.jq_valid             = jq_valid;
    assign io.jq_data              = mem_q[rd_ptr_q].data;
    assign io.jq_err               = mem_q[rd_ptr_q].err;
    assign io.jq_err_id            = mem_q[rd_ptr_q].err_id;
    assign io.count                = count_q;
    assign io.overflow             = overflow_q;
    assign io.rsv_err              = rsv_err_q;
endmodule
